snitch_clkdiv2_bridge: RTL and testbench
========================================

SNITCH_CLKDIV2_BRIDGE -- requirements
Module: snitch_clkdiv2_bridge

Interface
REQ-001 Parameter DataWidth, default 32: request payload width.
REQ-002 Parameter RspWidth, default 32: response payload width.
REQ-003 The module SHALL have one clock and a synchronous, active-high reset; all ports are in the clk_i domain.
REQ-004 clk_i  in  1  fast clock, the clock fed to the /2 divider.
REQ-005 rst_i  in  1  synchronous active-high reset.
REQ-006 test_mode_i  in  1  divider bypass (DFT), quasi-static.
REQ-007 bypass_i  in  1  divider bypass (functional), quasi-static.
REQ-008 slow_strobe_o  out  1  high in fast cycles whose closing edge is a slow-clock rising edge.
REQ-009 req_valid_i / req_ready_o / req_data_i  in/out/in  1/1/DataWidth  fast-side request.
REQ-010 req_valid_o / req_ready_i / req_data_o  out/in/out  1/1/DataWidth  slow-side request.
REQ-011 rsp_valid_i / rsp_ready_o / rsp_data_i  in/out/in  1/1/RspWidth  slow-side response.
REQ-012 rsp_valid_o / rsp_ready_i / rsp_data_o  out/in/out  1/1/RspWidth  fast-side response.

Function
REQ-013 Phase flop phase_q SHALL reset to 0 and toggle every cycle, mirroring the divider flop.
REQ-014 slow_strobe_o SHALL equal ~phase_q | test_mode_i | bypass_i.
REQ-015 All slow-side outputs (req_valid_o, req_data_o, rsp_ready_o) SHALL change only on clock edges closing strobe cycles.
REQ-016 Slow-side handshakes SHALL count only in strobe cycles; slow-side valid/ready seen high in a non-strobe cycle SHALL have no effect.
REQ-017 Request path: one-entry skid register plus output register; req_ready_o = ~skid_full.
REQ-018 In a strobe cycle with output register empty or req_ready_i high: load from skid if full; else load req_data_i directly if req_valid_i (skid untouched); else clear req_valid_o.
REQ-019 In a non-strobe cycle, a fast-side request handshake SHALL write the skid.
REQ-020 In a strobe cycle where the output register cannot load and the skid is empty, a fast-side handshake SHALL write the skid.
REQ-021 Request latency SHALL be one cycle (accepted in a strobe cycle) or two cycles (accepted in a non-strobe cycle) to req_valid_o; no data loss, duplication or reordering.
REQ-022 Response path: 2-entry FIFO; push = strobe & rsp_valid_i & rsp_ready_o; pop = rsp_valid_o & rsp_ready_i in any cycle.
REQ-023 rsp_valid_o = FIFO non-empty; rsp_data_o = FIFO head.
REQ-024 rsp_ready_o SHALL be registered and updated only in strobe cycles to (count_next < 2).
REQ-025 Simultaneous push and pop with count 2 SHALL NOT occur (ready low); with count 1 SHALL leave count 1.
REQ-026 In bypass (strobe constantly 1), the block SHALL behave as a 1-cycle registered pipe in both directions.
REQ-027 Changing test_mode_i/bypass_i while any buffer is non-empty is undefined; the phase flop keeps toggling regardless.

Reset
REQ-028 Reset SHALL set: phase_q=0, slow_strobe_o=1, req_ready_o=1, req_valid_o=0, rsp_ready_o=1, rsp_valid_o=0, FIFO count=0, skid empty.
REQ-029 Reset asserted mid-transfer SHALL discard all buffered entries in the same cycle; data outputs are don't-care while valid=0.

Structure
REQ-030 No shared package types are required; phase encoding and FIFO depth are local constants.
REQ-031 Phase flop and strobe logic SHALL be one sub-module, snitch_clkdiv2_phase, reusable by other slow-domain bridges.

Verification
REQ-032 Reset release, no traffic -> slow_strobe_o pattern 1,0,1,0...; req_valid_o=0, rsp_ready_o=1.
REQ-033 req 0xA5A5_0001 accepted in strobe cycle -> req_valid_o=1 next cycle, held exactly 2 cycles with req_ready_i=1.
REQ-034 Back-to-back requests 1,2,3 with req_ready_i=0 for 3 slow cycles -> req_ready_o drops after 2 accepted; output order 1,2,3, no duplicates.
REQ-035 rsp_valid_i=1 for 3 slow cycles (0x10,0x11,0x12), rsp_ready_i=0 -> exactly 2 captured, rsp_ready_o low from next slow edge; draining yields 0x10,0x11, then 0x12.
REQ-036 bypass_i=1 -> strobe constant 1, request and response each appear after exactly 1 cycle.
REQ-037 rst_i pulsed with both paths full -> all valids 0 and readies 1 the following cycle; no stale data emitted afterwards.

Source files
------------

// File: rtl/snitch_clkdiv2_bridge_pkg.sv
// Local constants shared by the clk/2 bridge and its phase generator.
// Phase encoding and response FIFO sizing live here so both files agree.
package snitch_clkdiv2_bridge_pkg;

  // Phase value during which the divided clock is about to rise.
  localparam logic PhaseStrobe = 1'b0;

  localparam int unsigned RspFifoDepth = 2;
  localparam int unsigned RspCntWidth  = $clog2(RspFifoDepth + 1);
  localparam int unsigned RspPtrWidth  = $clog2(RspFifoDepth);

  typedef logic [RspCntWidth-1:0] rsp_cnt_t;
  typedef logic [RspPtrWidth-1:0] rsp_ptr_t;

  function automatic logic rsp_has_space(input rsp_cnt_t cnt);
    return cnt < rsp_cnt_t'(RspFifoDepth);
  endfunction

endpackage

// File: rtl/snitch_clkdiv2_phase.sv
// Phase tracker for a /2 clock divider: mirrors the divider flop and flags
// the fast cycles whose closing edge is a slow-clock rising edge.
module snitch_clkdiv2_phase
  import snitch_clkdiv2_bridge_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic test_mode_i,
  input  logic bypass_i,
  output logic strobe_o
);

  logic phase_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase_q <= PhaseStrobe;
    end else begin
      phase_q <= ~phase_q;
    end
  end

  // Either bypass turns every fast edge into a slow edge.
  assign strobe_o = (phase_q == PhaseStrobe) | test_mode_i | bypass_i;

endmodule

// File: rtl/snitch_clkdiv2_bridge.sv
// Fast-to-slow (/2) handshake bridge: skid + output register on the request
// path, 2-entry FIFO on the response path; slow-side state moves on strobes only.
module snitch_clkdiv2_bridge
  import snitch_clkdiv2_bridge_pkg::*;
#(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned RspWidth  = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 test_mode_i,
  input  logic                 bypass_i,
  output logic                 slow_strobe_o,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [DataWidth-1:0] req_data_i,
  output logic                 req_valid_o,
  input  logic                 req_ready_i,
  output logic [DataWidth-1:0] req_data_o,
  input  logic                 rsp_valid_i,
  output logic                 rsp_ready_o,
  input  logic [RspWidth-1:0]  rsp_data_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [RspWidth-1:0]  rsp_data_o
);

  logic strobe;

  snitch_clkdiv2_phase i_phase (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .test_mode_i (test_mode_i),
    .bypass_i    (bypass_i),
    .strobe_o    (strobe)
  );

  assign slow_strobe_o = strobe;

  // ---------------------------------------------------------------- request
  logic                 skid_full_q, skid_full_d;
  logic [DataWidth-1:0] skid_data_q, skid_data_d;
  logic                 out_valid_q, out_valid_d;
  logic [DataWidth-1:0] out_data_q, out_data_d;
  logic                 req_hs;
  logic                 out_free;

  assign req_ready_o = ~skid_full_q;
  assign req_hs      = req_valid_i & req_ready_o;
  assign out_free    = ~out_valid_q | req_ready_i;

  always_comb begin
    skid_full_d = skid_full_q;
    skid_data_d = skid_data_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (strobe && out_free) begin
      if (skid_full_q) begin
        out_valid_d = 1'b1;
        out_data_d  = skid_data_q;
        skid_full_d = 1'b0;
      end else if (req_valid_i) begin
        out_valid_d = 1'b1;
        out_data_d  = req_data_i;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (req_hs) begin
      // Skid is empty here by construction of req_ready_o.
      skid_full_d = 1'b1;
      skid_data_d = req_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      skid_full_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      skid_full_q <= skid_full_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_ff @(posedge clk_i) begin
    skid_data_q <= skid_data_d;
    out_data_q  <= out_data_d;
  end

  assign req_valid_o = out_valid_q;
  assign req_data_o  = out_data_q;

  // --------------------------------------------------------------- response
  logic [RspWidth-1:0] rsp_mem_q [RspFifoDepth];
  rsp_ptr_t            rsp_wr_ptr_q, rsp_rd_ptr_q;
  rsp_cnt_t            rsp_cnt_q, rsp_cnt_d;
  logic                rsp_ready_q, rsp_ready_d;
  logic                rsp_push, rsp_pop;

  assign rsp_valid_o = (rsp_cnt_q != '0);
  assign rsp_data_o  = rsp_mem_q[rsp_rd_ptr_q];
  assign rsp_ready_o = rsp_ready_q;
  assign rsp_push    = strobe & rsp_valid_i & rsp_ready_q;
  assign rsp_pop     = rsp_valid_o & rsp_ready_i;

  always_comb begin
    rsp_cnt_d = rsp_cnt_q;
    case ({rsp_push, rsp_pop})
      2'b10:   rsp_cnt_d = rsp_cnt_q + rsp_cnt_t'(1);
      2'b01:   rsp_cnt_d = rsp_cnt_q - rsp_cnt_t'(1);
      default: rsp_cnt_d = rsp_cnt_q;
    endcase
    // Ready only moves with the slow clock; pops in between can only free space.
    rsp_ready_d = strobe ? rsp_has_space(rsp_cnt_d) : rsp_ready_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_cnt_q    <= '0;
      rsp_wr_ptr_q <= '0;
      rsp_rd_ptr_q <= '0;
      rsp_ready_q  <= 1'b1;
    end else begin
      rsp_cnt_q   <= rsp_cnt_d;
      rsp_ready_q <= rsp_ready_d;
      if (rsp_push) begin
        rsp_wr_ptr_q <= rsp_wr_ptr_q + rsp_ptr_t'(1);
      end
      if (rsp_pop) begin
        rsp_rd_ptr_q <= rsp_rd_ptr_q + rsp_ptr_t'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rsp_push) begin
      rsp_mem_q[rsp_wr_ptr_q] <= rsp_data_i;
    end
  end

endmodule

// File: tb/tb_snitch_clkdiv2_bridge.sv
// Directed bench for the clk/2 bridge: per-cycle vector table plus
// hand-written sequences for back-pressure, FIFO fill/drain and reset.
module tb_snitch_clkdiv2_bridge;

  logic        clk_i = 1'b0;
  logic        rst_i, test_mode_i, bypass_i;
  logic        slow_strobe_o;
  logic        req_valid_i, req_ready_o, req_valid_o, req_ready_i;
  logic [31:0] req_data_i, req_data_o;
  logic        rsp_valid_i, rsp_ready_o, rsp_valid_o, rsp_ready_i;
  logic [31:0] rsp_data_i, rsp_data_o;

  always #5 clk_i = ~clk_i;

  snitch_clkdiv2_bridge #(.DataWidth(32), .RspWidth(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .test_mode_i(test_mode_i), .bypass_i(bypass_i),
    .slow_strobe_o(slow_strobe_o),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_data_i(req_data_i),
    .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_data_o(req_data_o),
    .rsp_valid_i(rsp_valid_i), .rsp_ready_o(rsp_ready_o), .rsp_data_i(rsp_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o)
  );

  typedef struct {
    logic        byp, rq_v;
    logic [31:0] rq_d;
    logic        rq_rdy, rs_v;
    logic [31:0] rs_d;
    logic        rs_rdy;
    logic        e_stb, e_rq_rdy, e_rq_v;
    logic [31:0] e_rq_d;
    logic        e_rs_rdy, e_rs_v;
    logic [31:0] e_rs_d;
  } vec_t;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] req_mon[$];
  logic [31:0] rsp_mon[$];
  vec_t        vecs[22];

  function automatic vec_t mk(input logic byp, rq_v, input logic [31:0] rq_d,
                              input logic rq_rdy, rs_v, input logic [31:0] rs_d,
                              input logic rs_rdy, e_stb, e_rq_rdy, e_rq_v,
                              input logic [31:0] e_rq_d, input logic e_rs_rdy, e_rs_v,
                              input logic [31:0] e_rs_d);
    vec_t v;
    v.byp = byp; v.rq_v = rq_v; v.rq_d = rq_d; v.rq_rdy = rq_rdy;
    v.rs_v = rs_v; v.rs_d = rs_d; v.rs_rdy = rs_rdy;
    v.e_stb = e_stb; v.e_rq_rdy = e_rq_rdy; v.e_rq_v = e_rq_v; v.e_rq_d = e_rq_d;
    v.e_rs_rdy = e_rs_rdy; v.e_rs_v = e_rs_v; v.e_rs_d = e_rs_d;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic chk_q(input string name, input logic [31:0] act[$],
                       input logic [31:0] exp[$]);
    chk({name, " count"}, 0, act.size(), exp.size());
    for (int i = 0; i < exp.size() && i < act.size(); i++) chk(name, i, act[i], exp[i]);
  endtask

  // One fast cycle: record slow-side deliveries, then step past the edge.
  task automatic cyc();
    #4;
    if (slow_strobe_o === 1'b1 && req_valid_o === 1'b1 && req_ready_i)
      req_mon.push_back(req_data_o);
    if (rsp_valid_o === 1'b1 && rsp_ready_i)
      rsp_mon.push_back(rsp_data_o);
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_strobe();
    for (int i = 0; i < 4; i++) begin
      if (slow_strobe_o === 1'b1) return;
      cyc();
    end
    chk("strobe timeout", 0, slow_strobe_o, 1'b1);
  endtask

  task automatic idle_inputs();
    bypass_i = 0; test_mode_i = 0;
    req_valid_i = 0; req_data_i = '0; req_ready_i = 0;
    rsp_valid_i = 0; rsp_data_i = '0; rsp_ready_i = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // byp rq_v rq_d rq_rdy rs_v rs_d rs_rdy | stb rq_rdy rq_v rq_d rs_rdy rs_v rs_d
    vecs[0]  = mk(0,0,0,0,0,0,0,               0,1,0,0,1,0,0);
    vecs[1]  = mk(0,0,0,0,0,0,0,               1,1,0,0,1,0,0);
    vecs[2]  = mk(0,0,0,0,0,0,0,               0,1,0,0,1,0,0);
    vecs[3]  = mk(0,0,0,0,0,0,0,               1,1,0,0,1,0,0);
    vecs[4]  = mk(0,1,32'hA5A5_0001,1,0,0,0,   0,1,1,32'hA5A5_0001,1,0,0);
    vecs[5]  = mk(0,0,0,1,0,0,0,               1,1,1,32'hA5A5_0001,1,0,0);
    vecs[6]  = mk(0,0,0,1,0,0,0,               0,1,0,0,1,0,0);
    vecs[7]  = mk(0,0,0,0,0,0,0,               1,1,0,0,1,0,0);
    vecs[8]  = mk(0,0,0,0,0,0,0,               0,1,0,0,1,0,0);
    vecs[9]  = mk(0,1,32'h0000_BEEF,1,0,0,0,   1,0,0,0,1,0,0);
    vecs[10] = mk(0,0,0,1,0,0,0,               0,1,1,32'h0000_BEEF,1,0,0);
    vecs[11] = mk(0,0,0,1,0,0,0,               1,1,1,32'h0000_BEEF,1,0,0);
    vecs[12] = mk(0,0,0,1,0,0,0,               0,1,0,0,1,0,0);
    vecs[13] = mk(0,0,0,0,1,32'h77,0,          1,1,0,0,1,0,0);
    vecs[14] = mk(0,0,0,0,0,0,0,               0,1,0,0,1,0,0);
    vecs[15] = mk(0,0,0,0,0,0,0,               1,1,0,0,1,0,0);
    vecs[16] = mk(0,0,0,0,1,32'h55,1,          0,1,0,0,1,1,32'h55);
    vecs[17] = mk(0,0,0,0,0,0,1,               1,1,0,0,1,0,0);
    vecs[18] = mk(1,1,32'h1111_1111,1,1,32'h22,1, 1,1,1,32'h1111_1111,1,1,32'h22);
    vecs[19] = mk(1,1,32'h3333_3333,1,1,32'h44,1, 1,1,1,32'h3333_3333,1,1,32'h44);
    vecs[20] = mk(1,0,0,1,0,0,1,               1,1,0,0,1,0,0);
    vecs[21] = mk(0,0,0,0,0,0,0,               1,1,0,0,1,0,0);

    idle_inputs();
    rst_i = 1;
    cyc();
    cyc();
    chk("rst strobe", 0, slow_strobe_o, 1'b1);
    chk("rst req_ready", 0, req_ready_o, 1'b1);
    chk("rst req_valid", 0, req_valid_o, 1'b0);
    chk("rst rsp_ready", 0, rsp_ready_o, 1'b1);
    chk("rst rsp_valid", 0, rsp_valid_o, 1'b0);
    rst_i = 0;

    foreach (vecs[i]) begin
      bypass_i = vecs[i].byp;
      req_valid_i = vecs[i].rq_v; req_data_i = vecs[i].rq_d; req_ready_i = vecs[i].rq_rdy;
      rsp_valid_i = vecs[i].rs_v; rsp_data_i = vecs[i].rs_d; rsp_ready_i = vecs[i].rs_rdy;
      cyc();
      chk("vec strobe", i, slow_strobe_o, vecs[i].e_stb);
      chk("vec req_ready", i, req_ready_o, vecs[i].e_rq_rdy);
      chk("vec req_valid", i, req_valid_o, vecs[i].e_rq_v);
      if (vecs[i].e_rq_v) chk("vec req_data", i, req_data_o, vecs[i].e_rq_d);
      chk("vec rsp_ready", i, rsp_ready_o, vecs[i].e_rs_rdy);
      chk("vec rsp_valid", i, rsp_valid_o, vecs[i].e_rs_v);
      if (vecs[i].e_rs_v) chk("vec rsp_data", i, rsp_data_o, vecs[i].e_rs_d);
    end

    // Back-pressured request burst 1,2,3.
    idle_inputs();
    wait_strobe();
    req_mon.delete();
    rsp_mon.delete();
    req_valid_i = 1; req_data_i = 32'd1;
    cyc();
    chk("bp first valid", 0, req_valid_o, 1'b1);
    chk("bp first data", 0, req_data_o, 32'd1);
    chk("bp ready after 1", 0, req_ready_o, 1'b1);
    req_data_i = 32'd2;
    cyc();
    chk("bp ready after 2", 0, req_ready_o, 1'b0);
    req_data_i = 32'd3;
    repeat (4) cyc();
    chk("bp held data", 0, req_data_o, 32'd1);
    chk("bp still stalled", 0, req_ready_o, 1'b0);
    req_ready_i = 1;
    cyc();
    chk("bp skid drained", 0, req_data_o, 32'd2);
    chk("bp ready reopen", 0, req_ready_o, 1'b1);
    cyc();
    req_valid_i = 0;
    repeat (4) cyc();
    chk("bp valid idle", 0, req_valid_o, 1'b0);
    chk_q("bp order", req_mon, '{32'd1, 32'd2, 32'd3});

    // Response FIFO fill with no fast-side consumer, then drain.
    idle_inputs();
    wait_strobe();
    rsp_mon.delete();
    rsp_valid_i = 1; rsp_data_i = 32'h10;
    cyc();
    chk("fifo ready after 1", 0, rsp_ready_o, 1'b1);
    chk("fifo head 10", 0, rsp_data_o, 32'h10);
    rsp_data_i = 32'h11;
    cyc();
    cyc();
    chk("fifo ready after 2", 0, rsp_ready_o, 1'b0);
    rsp_data_i = 32'h12;
    repeat (3) cyc();
    chk("fifo still full", 0, rsp_ready_o, 1'b0);
    chk("fifo head held", 0, rsp_data_o, 32'h10);
    rsp_ready_i = 1;
    cyc();
    chk("fifo head 11", 0, rsp_data_o, 32'h11);
    chk("fifo ready reopen", 0, rsp_ready_o, 1'b1);
    cyc();
    chk("fifo empty", 0, rsp_valid_o, 1'b0);
    cyc();
    chk("fifo 12 valid", 0, rsp_valid_o, 1'b1);
    chk("fifo 12 data", 0, rsp_data_o, 32'h12);
    rsp_valid_i = 0;
    cyc();
    chk("fifo drained", 0, rsp_valid_o, 1'b0);
    chk_q("fifo order", rsp_mon, '{32'h10, 32'h11, 32'h12});

    // Reset with both paths holding data.
    idle_inputs();
    wait_strobe();
    req_valid_i = 1; req_data_i = 32'hDEAD_0001; rsp_valid_i = 1; rsp_data_i = 32'hC1;
    cyc();
    req_data_i = 32'hDEAD_0002; rsp_data_i = 32'hC2;
    cyc();
    req_data_i = 32'hDEAD_0003;
    cyc();
    chk("full req_ready", 0, req_ready_o, 1'b0);
    chk("full req_valid", 0, req_valid_o, 1'b1);
    chk("full rsp_ready", 0, rsp_ready_o, 1'b0);
    chk("full rsp_valid", 0, rsp_valid_o, 1'b1);
    idle_inputs();
    rst_i = 1;
    cyc();
    rst_i = 0;
    chk("midrst req_valid", 0, req_valid_o, 1'b0);
    chk("midrst rsp_valid", 0, rsp_valid_o, 1'b0);
    chk("midrst req_ready", 0, req_ready_o, 1'b1);
    chk("midrst rsp_ready", 0, rsp_ready_o, 1'b1);
    chk("midrst strobe", 0, slow_strobe_o, 1'b1);
    req_mon.delete();
    rsp_mon.delete();
    req_ready_i = 1; rsp_ready_i = 1;
    repeat (6) cyc();
    chk("post-rst req stale", 0, req_mon.size(), 0);
    chk("post-rst rsp stale", 0, rsp_mon.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
